// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: start/busy/done handshake and operand/result bus of the multi-cycle ALU
interface alu_muldiv_seq_if #(parameter int WIDTH = 32);
  logic start;
  logic [2:0] sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic ov;
  logic div0;
  modport master (output start, sel, a, b, input busy, done, result, hi, lo, ov, div0);
  modport slave (input start, sel, a, b, output busy, done, result, hi, lo, ov, div0);
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: registered ALU with iterative shift-add MULT/MULTU and restoring DIVU into HI/LO
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  localparam int CNTW = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic rst_n,
  alu_muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam int M = WIDTH - 1;
  state_t st;
  logic [2:0] op;
  logic [CNTW-1:0] cnt;
  logic [WIDTH-1:0] ph, pl, rb, addsub, alu, ma, mb, nh, nl, sr;
  logic [WIDTH:0] sum, sh;
  logic [2*WIDTH-1:0] prod, fin;
  logic neg, ge, ovf, mul, sgn;
  always_comb begin
    addsub = bus.sel[0] ? bus.a - bus.b : bus.a + bus.b;
    ovf = ~bus.sel[2] & ~bus.sel[1] & (bus.a[M] ^ bus.b[M] ^ ~bus.sel[0]) & (bus.a[M] ^ addsub[M]);
    alu = bus.sel == 3'b010 ? bus.a & bus.b :
          bus.sel == 3'b011 ? bus.a | bus.b :
          bus.sel == 3'b100 ? {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)} : addsub;
    mul = bus.sel[2] & |bus.sel[1:0];
    sgn = bus.sel == 3'b101;
    ma = sgn & bus.a[M] ? -bus.a : bus.a;
    mb = sgn & bus.b[M] ? -bus.b : bus.b;
    // multiply: add multiplicand into the upper half, shift the 2W accumulator right
    sum = {1'b0, ph} + {1'b0, rb};
    // divide: remainder lives in ph, dividend shifts out of pl while quotient bits shift in
    sh = {ph, pl[M]};
    ge = sh >= {1'b0, rb};
    sr = sh[M:0] - rb;
    nh = op == 3'b111 ? (ge ? sr : sh[M:0]) : (pl[0] ? sum[WIDTH:1] : {1'b0, ph[M:1]});
    nl = op == 3'b111 ? {pl[M-1:0], ge} : {pl[0] ? sum[0] : ph[0], pl[M:1]};
    prod = {nh, nl};
    fin = neg ? -prod : prod;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      op <= '0;
      cnt <= '0;
      ph <= '0;
      pl <= '0;
      rb <= '0;
      neg <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
      bus.hi <= '0;
      bus.lo <= '0;
      bus.ov <= 1'b0;
      bus.div0 <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
          op <= bus.sel;
          cnt <= '0;
          ph <= '0;
          pl <= bus.sel == 3'b111 ? bus.a : ma;
          rb <= bus.sel == 3'b111 ? bus.b : mb;
          neg <= sgn & (bus.a[M] ^ bus.b[M]);
          bus.ov <= ovf;
          bus.div0 <= 1'b0;
          bus.busy <= mul;
          bus.done <= ~mul;
          if (!mul) bus.result <= alu;
          st <= mul ? EXEC : DONE;
        end
        EXEC: begin
          ph <= nh;
          pl <= nl;
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(WIDTH - 1)) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.hi <= fin[2*WIDTH-1:WIDTH];
            bus.lo <= fin[M:0];
            bus.result <= fin[M:0];
            bus.div0 <= op == 3'b111 && rb == '0;
            st <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed scoreboard bench for the multi-cycle ALU handshake, ALU ops and HI/LO results
module tb_alu_muldiv_seq;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_muldiv_seq_if #(.WIDTH(W)) bus ();
  alu_muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    string tag;
    logic [W-1:0] res, hi, lo;
    logic ov, div0;
    int lat, busy;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    logic [63:0] p;
    e.tag = tag;
    e.ov = 1'b0;
    e.div0 = 1'b0;
    e.lat = 1;
    e.busy = 0;
    e.hi = cur_hi;
    e.lo = cur_lo;
    s = '0;
    p = '0;
    case (sel)
      3'b000: begin s = {a[W-1], a} + {b[W-1], b}; e.res = s[W-1:0]; e.ov = s[W] ^ s[W-1]; end
      3'b001: begin s = {a[W-1], a} - {b[W-1], b}; e.res = s[W-1:0]; e.ov = s[W] ^ s[W-1]; end
      3'b010: e.res = a & b;
      3'b011: e.res = a | b;
      3'b100: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      default: begin
        if (sel == 3'b101) p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        else if (sel == 3'b110) p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        else if (b == 0) begin p = {a, {W{1'b1}}}; e.div0 = 1'b1; end
        else p = {a % b, a / b};
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.res = p[31:0];
        e.lat = W + 1;
        e.busy = W;
        cur_hi = e.hi;
        cur_lo = e.lo;
      end
    endcase
    q.push_back(e);
  endtask
  task automatic run(input string tag, input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int inj_mid, input bit inj_done);
    exp_t e;
    int lat, busy;
    push(tag, sel, a, b);
    bus.start = 1'b1;
    bus.sel = sel;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~a;
    bus.b = b + 7;
    lat = 1;
    busy = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy++;
      bus.start = (lat == inj_mid);
      bus.sel = 3'b000;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    e = q.pop_front();
    chk({e.tag, ".latency"}, lat, e.lat);
    chk({e.tag, ".busy_cycles"}, busy, e.busy);
    chk({e.tag, ".result"}, bus.result, e.res);
    chk({e.tag, ".hi"}, bus.hi, e.hi);
    chk({e.tag, ".lo"}, bus.lo, e.lo);
    chk({e.tag, ".ov"}, bus.ov, e.ov);
    chk({e.tag, ".div0"}, bus.div0, e.div0);
    if (inj_done) begin
      bus.start = 1'b1;
      bus.sel = 3'b011;
      bus.a = '1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({e.tag, ".done_pulse"}, {bus.done, bus.busy}, 2'b00);
    if (inj_done) chk({e.tag, ".held_result"}, bus.result, e.res);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.sel = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("reset", {bus.busy, bus.done, bus.ov, bus.div0, bus.result, bus.hi, bus.lo}, '0);
    rst_n = 1'b1;
    run("add_ovf", 3'b000, 32'h7FFFFFFF, 32'h1, 0, 1'b0);
    run("sub", 3'b001, 32'd5, 32'd9, 0, 1'b0);
    run("slt", 3'b100, -32'sd4, 32'd3, 0, 1'b0);
    run("sub_ovf", 3'b001, 32'h80000000, 32'h1, 0, 1'b0);
    run("and", 3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
    run("or", 3'b011, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
    run("mult", 3'b101, -32'sd3, 32'd7, 10, 1'b0);
    run("slt_hold", 3'b100, 32'd3, -32'sd4, 0, 1'b1);
    run("multu", 3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    run("mult_minmin", 3'b101, 32'h80000000, 32'h80000000, 0, 1'b0);
    run("divu", 3'b111, 32'd100, 32'd7, 0, 1'b0);
    run("divu0", 3'b111, 32'd123, 32'd0, 0, 1'b1);
    run("add_after_div0", 3'b000, 32'd1, 32'd2, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run("rnd_mult", 3'b101, $urandom, $urandom, 0, 1'b0);
      run("rnd_divu", 3'b111, $urandom, $urandom_range(1, 1 << 20), 0, 1'b0);
    end
    bus.start = 1'b1;
    bus.sel = 3'b110;
    bus.a = 32'hDEADBEEF;
    bus.b = 32'h12345678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset", {bus.busy, bus.done, bus.hi, bus.lo}, '0);
    rst_n = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
    run("add_post_reset", 3'b000, 32'd40, 32'd2, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
